// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one combinational data-memory port between the IFU
// (read-only) and the LSU (read/write). One transaction is in flight at a
// time; every accepted request produces exactly one single-cycle mem_ren or
// mem_wen pulse, LATENCY cycles after acceptance, followed by a held response.
module dmem_arbiter #(
    parameter int XLEN    = 32,
    parameter int LATENCY = 1
) (
    input  logic            clock,
    input  logic            reset,

    input  logic            ifu_req_valid,
    output logic            ifu_req_ready,
    input  logic [XLEN-1:0] ifu_req_addr,
    output logic            ifu_resp_valid,
    input  logic            ifu_resp_ready,
    output logic [XLEN-1:0] ifu_resp_rdata,

    input  logic            lsu_req_valid,
    output logic            lsu_req_ready,
    input  logic [XLEN-1:0] lsu_req_addr,
    input  logic            lsu_req_wen,
    input  logic [7:0]      lsu_req_wmask,
    input  logic [XLEN-1:0] lsu_req_wdata,
    output logic            lsu_resp_valid,
    input  logic            lsu_resp_ready,
    output logic [XLEN-1:0] lsu_resp_rdata,

    output logic [XLEN-1:0] mem_addr,
    output logic            mem_ren,
    output logic            mem_wen,
    output logic [7:0]      mem_wmask,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_e;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } owner_e;

    localparam logic [7:0] CNT_INIT = 8'(LATENCY - 1);

    state_e          state_q, state_d;
    owner_e          last_q, last_d;
    owner_e          owner_q, owner_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic            wen_q, wen_d;
    logic [7:0]      wmask_q, wmask_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic [7:0]      cnt_q, cnt_d;

    logic            grant_ifu;
    logic            grant_lsu;
    logic            owner_resp_ready;

    // Round-robin grant: a lone requester always wins; on a tie the side
    // that did not win last time is chosen.
    always_comb begin
        grant_ifu = ifu_req_valid && (!lsu_req_valid || (last_q == OWN_LSU));
        grant_lsu = lsu_req_valid && (!ifu_req_valid || (last_q == OWN_IFU));
        owner_resp_ready = (owner_q == OWN_LSU) ? lsu_resp_ready : ifu_resp_ready;
    end

    // Next-state and output decode for the IDLE/WAIT/RESP transaction FSM.
    always_comb begin
        state_d        = state_q;
        last_d         = last_q;
        owner_d        = owner_q;
        addr_d         = addr_q;
        wen_d          = wen_q;
        wmask_d        = wmask_q;
        wdata_d        = wdata_q;
        rdata_d        = rdata_q;
        cnt_d          = cnt_q;
        ifu_req_ready  = 1'b0;
        lsu_req_ready  = 1'b0;
        ifu_resp_valid = 1'b0;
        lsu_resp_valid = 1'b0;
        mem_ren        = 1'b0;
        mem_wen        = 1'b0;
        mem_wmask      = '0;

        case (state_q)
            S_IDLE: begin
                // Readiness is suppressed during reset so no handshake is
                // ever reported for a cycle whose capture reset discards.
                ifu_req_ready = grant_ifu && !reset;
                lsu_req_ready = grant_lsu && !reset;
                if (grant_ifu) begin
                    owner_d = OWN_IFU;
                    last_d  = OWN_IFU;
                    addr_d  = ifu_req_addr;
                    wen_d   = 1'b0;
                    wmask_d = '0;
                    wdata_d = '0;
                    cnt_d   = CNT_INIT;
                    state_d = S_WAIT;
                end else if (grant_lsu) begin
                    owner_d = OWN_LSU;
                    last_d  = OWN_LSU;
                    addr_d  = lsu_req_addr;
                    wen_d   = lsu_req_wen;
                    wmask_d = lsu_req_wmask;
                    wdata_d = lsu_req_wdata;
                    cnt_d   = CNT_INIT;
                    state_d = S_WAIT;
                end
            end

            S_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    // Issue cycle: the single memory access of this request.
                    // Gated by reset so an abandoned transaction never fires.
                    if (!reset) begin
                        mem_ren   = !wen_q;
                        mem_wen   = wen_q;
                        mem_wmask = wmask_q;
                    end
                    rdata_d = wen_q ? '0 : mem_rdata;
                    state_d = S_RESP;
                end
            end

            S_RESP: begin
                ifu_resp_valid = (owner_q == OWN_IFU);
                lsu_resp_valid = (owner_q == OWN_LSU);
                if (owner_resp_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and latched-transaction registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            last_q  <= OWN_LSU;
            owner_q <= OWN_IFU;
            addr_q  <= '0;
            wen_q   <= 1'b0;
            wmask_q <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            addr_q  <= addr_d;
            wen_q   <= wen_d;
            wmask_q <= wmask_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
        end
    end

    assign mem_addr       = addr_q;
    assign mem_wdata      = wdata_q;
    assign ifu_resp_rdata = rdata_q;
    assign lsu_resp_rdata = rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: three instances (LATENCY 1, 3, 4) share one stream
// of requester inputs. Each instance has a transaction-level model that
// predicts every output every cycle; directed phases add literal checks.
module tb_dmem_arbiter;

    localparam int N = 3;

    logic clock;
    logic reset;

    logic        ifu_req_valid;
    logic [31:0] ifu_req_addr;
    logic        ifu_resp_ready;
    logic        lsu_req_valid;
    logic [31:0] lsu_req_addr;
    logic        lsu_req_wen;
    logic [7:0]  lsu_req_wmask;
    logic [31:0] lsu_req_wdata;
    logic        lsu_resp_ready;

    logic [N-1:0] ifu_req_ready;
    logic [N-1:0] ifu_resp_valid;
    logic [N-1:0] lsu_req_ready;
    logic [N-1:0] lsu_resp_valid;
    logic [N-1:0] mem_ren;
    logic [N-1:0] mem_wen;
    logic [31:0]  ifu_resp_rdata [N];
    logic [31:0]  lsu_resp_rdata [N];
    logic [31:0]  mem_addr       [N];
    logic [31:0]  mem_wdata      [N];
    logic [31:0]  mem_rdata      [N];
    logic [7:0]   mem_wmask      [N];

    int          n_checks = 0;
    int          n_fail   = 0;
    int unsigned cyc      = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Memory contents: one fixed word, everything else varies with time so
    // a response that is not captured at the issue cycle shows up as wrong.
    function automatic logic [31:0] memfn(input logic [31:0] a, input int unsigned c);
        if (a == 32'h8000_0000) return 32'h0000_0413;
        return a ^ (c * 32'h9E37_79B1);
    endfunction

    task automatic check(input string name, input int inst,
                         input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s inst%0d cyc %0d: got %h expected %h", name, inst, cyc, act, exp);
        end
    endtask

    for (genvar g = 0; g < N; g++) begin : inst
        localparam int LAT = (g == 0) ? 1 : (g == 1) ? 3 : 4;

        dmem_arbiter #(.XLEN(32), .LATENCY(LAT)) u_dut (
            .clock         (clock),
            .reset         (reset),
            .ifu_req_valid (ifu_req_valid),
            .ifu_req_ready (ifu_req_ready[g]),
            .ifu_req_addr  (ifu_req_addr),
            .ifu_resp_valid(ifu_resp_valid[g]),
            .ifu_resp_ready(ifu_resp_ready),
            .ifu_resp_rdata(ifu_resp_rdata[g]),
            .lsu_req_valid (lsu_req_valid),
            .lsu_req_ready (lsu_req_ready[g]),
            .lsu_req_addr  (lsu_req_addr),
            .lsu_req_wen   (lsu_req_wen),
            .lsu_req_wmask (lsu_req_wmask),
            .lsu_req_wdata (lsu_req_wdata),
            .lsu_resp_valid(lsu_resp_valid[g]),
            .lsu_resp_ready(lsu_resp_ready),
            .lsu_resp_rdata(lsu_resp_rdata[g]),
            .mem_addr      (mem_addr[g]),
            .mem_ren       (mem_ren[g]),
            .mem_wen       (mem_wen[g]),
            .mem_wmask     (mem_wmask[g]),
            .mem_wdata     (mem_wdata[g]),
            .mem_rdata     (mem_rdata[g])
        );

        assign mem_rdata[g] = memfn(mem_addr[g], cyc);

        // Transaction model: an accepted request issues at accept+LAT and
        // responds from accept+LAT+1 until the owner's resp_ready.
        bit          busy     = 1'b0;
        bit          own_lsu  = 1'b0;
        bit          last_lsu = 1'b1;
        bit          t_wen    = 1'b0;
        bit [7:0]    t_wmask  = '0;
        bit [31:0]   t_addr   = '0;
        bit [31:0]   t_wdata  = '0;
        bit [31:0]   t_rdata  = '0;
        int unsigned t_issue  = 0;

        always @(negedge clock) begin
            bit       e_ir, e_lr, e_iv, e_lv, e_ren, e_wen, g_ifu, g_lsu;
            bit [7:0] e_wm;
            e_ir = 0; e_lr = 0; e_iv = 0; e_lv = 0; e_ren = 0; e_wen = 0;
            g_ifu = 0; g_lsu = 0; e_wm = '0;

            if (busy && cyc > t_issue) begin
                e_iv = !own_lsu;
                e_lv = own_lsu;
            end
            if (!reset) begin
                if (!busy) begin
                    if (ifu_req_valid && lsu_req_valid) begin
                        g_ifu = last_lsu;
                        g_lsu = !last_lsu;
                    end else begin
                        g_ifu = ifu_req_valid;
                        g_lsu = lsu_req_valid;
                    end
                    e_ir = g_ifu;
                    e_lr = g_lsu;
                end else if (cyc == t_issue) begin
                    e_ren = !t_wen;
                    e_wen = t_wen;
                    e_wm  = t_wmask;
                end
            end

            check("ctrl", g,
                  {18'b0, ifu_req_ready[g], lsu_req_ready[g], ifu_resp_valid[g],
                   lsu_resp_valid[g], mem_ren[g], mem_wen[g], mem_wmask[g]},
                  {18'b0, e_ir, e_lr, e_iv, e_lv, e_ren, e_wen, e_wm});
            if (!reset) begin
                check("mem_addr", g, mem_addr[g], t_addr);
                if (t_wen) check("mem_wdata", g, mem_wdata[g], t_wdata);
            end
            if (e_iv) check("ifu_rdata", g, ifu_resp_rdata[g], t_rdata);
            if (e_lv) check("lsu_rdata", g, lsu_resp_rdata[g], t_rdata);

            if (reset) begin
                busy = 0; last_lsu = 1; t_addr = '0; t_wdata = '0;
                t_wen = 0; t_wmask = '0;
            end else if (!busy) begin
                if (g_ifu) begin
                    busy = 1; own_lsu = 0; last_lsu = 0;
                    t_addr = ifu_req_addr; t_wen = 0; t_wmask = '0; t_wdata = '0;
                    t_issue = cyc + LAT;
                end else if (g_lsu) begin
                    busy = 1; own_lsu = 1; last_lsu = 1;
                    t_addr = lsu_req_addr; t_wen = lsu_req_wen;
                    t_wmask = lsu_req_wmask; t_wdata = lsu_req_wdata;
                    t_issue = cyc + LAT;
                end
            end else if (cyc == t_issue) begin
                t_rdata = t_wen ? 32'h0 : memfn(t_addr, cyc);
            end else if (cyc > t_issue && (own_lsu ? lsu_resp_ready : ifu_resp_ready)) begin
                busy = 0;
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        ifu_req_valid = 0; lsu_req_valid = 0; lsu_req_wen = 0;
        ifu_resp_ready = 1; lsu_resp_ready = 1;
    endtask

    task automatic do_reset(input int n);
        reset = 1;
        repeat (n) step();
        reset = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int nw, nr, seen, both, cnt, ren_at;
        bit [3:0] ord;

        reset = 1;
        ifu_req_addr = '0; lsu_req_addr = '0; lsu_req_wmask = '0; lsu_req_wdata = '0;
        idle_inputs();
        step();
        do_reset(1);

        // IFU read alone on the LATENCY=1 instance.
        ifu_req_valid = 1; ifu_req_addr = 32'h8000_0000;
        @(negedge clock);
        check("d1_ifu_ready", 0, 32'(ifu_req_ready[0]), 32'd1);
        step();
        ifu_req_valid = 0;
        @(negedge clock);
        check("d1_ren_c1", 0, 32'(mem_ren[0]), 32'd1);
        check("d1_addr_c1", 0, mem_addr[0], 32'h8000_0000);
        step();
        @(negedge clock);
        check("d1_ren_c2", 0, 32'(mem_ren[0]), 32'd0);
        check("d1_rvalid_c2", 0, 32'(ifu_resp_valid[0]), 32'd1);
        check("d1_rdata_c2", 0, ifu_resp_rdata[0], 32'h0000_0413);
        check("d1_lsu_rvalid", 0, 32'(lsu_resp_valid[0]), 32'd0);
        repeat (8) step();

        // LSU write on the LATENCY=1 instance: exactly one write pulse.
        lsu_req_valid = 1; lsu_req_wen = 1; lsu_req_addr = 32'h8000_1000;
        lsu_req_wdata = 32'hDEAD_BEEF; lsu_req_wmask = 8'h0F;
        nw = 0; nr = 0; seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            if (k == 0) check("d2_lsu_ready", 0, 32'(lsu_req_ready[0]), 32'd1);
            if (mem_wen[0]) begin
                nw++;
                check("d2_wmask", 0, 32'(mem_wmask[0]), 32'h0F);
                check("d2_wdata", 0, mem_wdata[0], 32'hDEAD_BEEF);
            end
            if (mem_ren[0]) nr++;
            if (lsu_resp_valid[0]) begin
                seen = 1;
                check("d2_rdata", 0, lsu_resp_rdata[0], 32'h0);
            end
            step();
            if (k == 0) begin lsu_req_valid = 0; lsu_req_wen = 0; end
        end
        check("d2_wen_pulses", 0, nw, 1);
        check("d2_ren_pulses", 0, nr, 0);
        check("d2_resp_seen", 0, seen, 1);

        // Continuous tie after reset: IFU, LSU, IFU, LSU.
        do_reset(1);
        ifu_req_valid = 1; lsu_req_valid = 1; lsu_req_wen = 0;
        ifu_req_addr = 32'h8000_0100; lsu_req_addr = 32'h8000_0200;
        ord = '0; cnt = 0; both = 0;
        for (int k = 0; k < 60 && cnt < 4; k++) begin
            @(negedge clock);
            if (ifu_req_ready[0]) begin ord[cnt] = 1'b0; cnt++; end
            else if (lsu_req_ready[0]) begin ord[cnt] = 1'b1; cnt++; end
            if (ifu_resp_valid[0] && lsu_resp_valid[0]) both++;
            step();
        end
        check("d3_grants", 0, cnt, 4);
        check("d3_order", 0, 32'(ord), 32'b1010);
        check("d3_both_valid", 0, both, 0);
        idle_inputs();
        repeat (8) step();

        // LATENCY=3 LSU read with response backpressure.
        do_reset(1);
        lsu_req_valid = 1; lsu_req_wen = 0; lsu_req_addr = 32'h8000_0000;
        lsu_resp_ready = 0;
        nr = 0; ren_at = -1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clock);
            if (k == 0) check("d4_lsu_ready", 1, 32'(lsu_req_ready[1]), 32'd1);
            if (mem_ren[1]) begin nr++; ren_at = k; end
            if (k >= 4 && k <= 8) begin
                check("d4_rvalid_held", 1, 32'(lsu_resp_valid[1]), 32'd1);
                check("d4_rdata_held", 1, lsu_resp_rdata[1], 32'h0000_0413);
            end
            if (k >= 1 && k <= 9) check("d4_ifu_blocked", 1, 32'(ifu_req_ready[1]), 32'd0);
            if (k == 10) check("d4_ifu_accept", 1, 32'(ifu_req_ready[1]), 32'd1);
            step();
            if (k == 0) begin
                lsu_req_valid = 0; ifu_req_valid = 1; ifu_req_addr = 32'h8000_0040;
            end
            if (k == 8) lsu_resp_ready = 1;
            if (k == 10) ifu_req_valid = 0;
        end
        check("d4_ren_pulses", 1, nr, 1);
        check("d4_ren_offset", 1, ren_at, 3);
        idle_inputs();
        repeat (8) step();

        // LATENCY=4 LSU write abandoned by reset while waiting.
        do_reset(1);
        lsu_req_valid = 1; lsu_req_wen = 1; lsu_req_addr = 32'h8000_2000;
        lsu_req_wdata = 32'h1234_5678; lsu_req_wmask = 8'hFF;
        nw = 0;
        for (int k = 0; k < 11; k++) begin
            @(negedge clock);
            if (k == 0) check("d5_lsu_ready", 2, 32'(lsu_req_ready[2]), 32'd1);
            if (mem_wen[2]) nw++;
            if (k == 3) begin
                check("d5_rst_ctrl", 2,
                      {18'b0, ifu_req_ready[2], lsu_req_ready[2], ifu_resp_valid[2],
                       lsu_resp_valid[2], mem_ren[2], mem_wen[2], mem_wmask[2]}, 32'h0);
                check("d5_rst_addr", 2, mem_addr[2], 32'h0);
                check("d5_rst_wdata", 2, mem_wdata[2], 32'h0);
            end
            if (k == 4) begin
                check("d5_tie_ifu", 2, 32'(ifu_req_ready[2]), 32'd1);
                check("d5_tie_lsu", 2, 32'(lsu_req_ready[2]), 32'd0);
            end
            step();
            if (k == 0) lsu_req_valid = 0;
            if (k == 1) reset = 1;
            if (k == 3) begin
                reset = 0; ifu_req_valid = 1; lsu_req_valid = 1; lsu_req_wen = 0;
            end
            if (k == 4) begin ifu_req_valid = 0; lsu_req_valid = 0; end
        end
        check("d5_wen_pulses", 2, nw, 0);
        idle_inputs();
        repeat (8) step();

        // Random traffic, occasional reset, random backpressure.
        repeat (3000) begin
            reset          = ($urandom_range(0, 199) == 0);
            ifu_req_valid  = $urandom_range(0, 1);
            lsu_req_valid  = $urandom_range(0, 1);
            ifu_req_addr   = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
            lsu_req_addr   = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
            lsu_req_wen    = $urandom_range(0, 1);
            lsu_req_wmask  = 8'($urandom);
            lsu_req_wdata  = $urandom;
            ifu_resp_ready = ($urandom_range(0, 9) < 7);
            lsu_resp_ready = ($urandom_range(0, 9) < 7);
            step();
        end
        reset = 0;
        idle_inputs();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single combinational DPI-backed data-memory port (addr/wen/wmask/wdata/ren/rdata) between the instruction-fetch unit (IFU, read-only) and the load/store unit (LSU, read/write).
- Gives each requester a valid/ready request channel and a valid/ready response channel.
- Inserts a programmable access latency to model slow memory.
- Guarantees exactly one single-cycle memory access (ren or wen pulse) per accepted request, so each DPI write fires once.

Parameters:
- XLEN, 32, address/data width.
- LATENCY, 1, cycles from request acceptance to the memory issue cycle; legal range 1..255.

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-high reset
- ifu_req_valid  input  1  IFU read request
- ifu_req_ready  output  1  IFU request accepted this cycle
- ifu_req_addr  input  XLEN  IFU read address
- ifu_resp_valid  output  1  IFU read data valid
- ifu_resp_ready  input  1  IFU consumes response
- ifu_resp_rdata  output  XLEN  IFU read data
- lsu_req_valid  input  1  LSU request
- lsu_req_ready  output  1  LSU request accepted this cycle
- lsu_req_addr  input  XLEN  LSU address
- lsu_req_wen  input  1  1 = write, 0 = read
- lsu_req_wmask  input  8  byte write mask
- lsu_req_wdata  input  XLEN  write data
- lsu_resp_valid  output  1  LSU response (read data or write ack)
- lsu_resp_ready  input  1  LSU consumes response
- lsu_resp_rdata  output  XLEN  LSU read data; 0 for writes
- mem_addr  output  XLEN  memory address
- mem_ren  output  1  memory read enable
- mem_wen  output  1  memory write enable
- mem_wmask  output  8  memory write mask
- mem_wdata  output  XLEN  memory write data
- mem_rdata  input  XLEN  combinational memory read data

Behaviour:
- Clocking and reset: single clock domain; reset is synchronous and active-high.
- Reset values:
  - state = IDLE; last_grant = LSU.
  - All *_req_ready and *_resp_valid = 0.
  - mem_ren, mem_wen = 0; mem_wmask = 0.
  - Latched addr/wdata/rdata = 0.
- One outstanding transaction total; requests are not pipelined.
- State IDLE:
  - Only one requester valid: that requester's req_ready = 1 combinationally.
  - Both valid: round-robin; grant the requester ≠ last_grant. The first tie after reset goes to IFU.
  - On handshake (valid & ready):
    - Latch owner, addr, wen (IFU forces 0), wmask (IFU forces 0), wdata.
    - Update last_grant; cnt = LATENCY-1; go to WAIT.
  - No requester valid: stay in IDLE; both readys = 0.
- State WAIT:
  - Both req_ready = 0.
  - cnt ≠ 0: decrement.
  - cnt = 0 (issue cycle):
    - mem_addr = latched addr.
    - Read: mem_ren = 1, mem_wen = 0. Write: mem_wen = 1, mem_ren = 0.
    - mem_wmask = latched wmask; mem_wdata = latched wdata.
    - Read: register mem_rdata into resp_rdata. Write: resp_rdata = 0.
    - Go to RESP.
- Timing:
  - Handshake in cycle T → issue cycle T+LATENCY → owner resp_valid from T+LATENCY+1.
  - LATENCY = 1 gives the minimum 2-cycle request→response.
- Outside the issue cycle:
  - mem_ren = mem_wen = 0; mem_wmask = 0.
  - mem_addr/mem_wdata hold the latched values; they are don't-care to memory.
- State RESP:
  - Owner's resp_valid = 1 with resp_rdata stable until resp_ready.
  - Non-owner resp_valid = 0; both req_ready = 0.
  - On resp_ready: go to IDLE. The next request can be accepted the following cycle.
- Backpressure: resp_ready held low keeps RESP indefinitely; no second memory access occurs.
- Requester inputs are sampled only at the handshake. Changes after acceptance have no effect.
- Reset mid-operation (WAIT or RESP):
  - Transaction is abandoned; no issue cycle occurs.
  - resp_valid drops the cycle after reset is asserted; last_grant returns to LSU.
- A write issues exactly one mem_wen cycle. A read issues exactly one mem_ren cycle.

Test Plan:
- IFU read alone, LATENCY = 1, addr 0x80000000, mem_rdata = 0x00000413 → ifu_req_ready in cycle 0; mem_ren = 1 in cycle 1 only; ifu_resp_valid in cycle 2 with rdata 0x00000413; lsu_resp_valid stays 0.
- LSU write addr 0x80001000, wdata 0xDEADBEEF, wmask 0x0F → exactly one cycle with mem_wen = 1, mem_wmask = 0x0F, mem_wdata = 0xDEADBEEF; mem_ren = 0 throughout; lsu_resp_valid with rdata 0.
- Both requesters valid continuously for 4 transactions after reset → grant order IFU, LSU, IFU, LSU; never more than one resp_valid at a time.
- LATENCY = 3, LSU read, lsu_resp_ready held low 5 cycles → issue exactly 3 cycles after acceptance; resp_valid and rdata stable for all 5 cycles; one mem_ren pulse; a new IFU request is not accepted until the cycle after the response handshake.
- Reset asserted in WAIT (LATENCY = 4) during an LSU write → mem_wen never asserted; all outputs at reset values next cycle; the first tie after reset is granted to IFU.
